// File: rtl/warp_fetcher_if.sv
// Program-memory consumer port shared by the warp fetcher (master) and the
// instruction memory controller (slave).
`ifndef INSTRUCTION_MEMORY_ADDRESS_WIDTH
`define INSTRUCTION_MEMORY_ADDRESS_WIDTH 16
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

interface warp_fetcher_if #(
    parameter int ADDR_WIDTH  = `INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int INSTR_WIDTH = `INSTRUCTION_WIDTH
);
    logic                   mem_read_valid;
    logic [ADDR_WIDTH-1:0]  mem_read_address;
    logic                   mem_read_ready;
    logic [INSTR_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/warp_fetcher.sv
// Round-robin instruction fetcher: arbitrates warp fetch requests onto a single
// program-memory port, one outstanding request at a time.
`ifndef INSTRUCTION_MEMORY_ADDRESS_WIDTH
`define INSTRUCTION_MEMORY_ADDRESS_WIDTH 16
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module warp_fetcher #(
    parameter int WARPS_PER_CORE = 4,
    parameter int ADDR_WIDTH     = `INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int INSTR_WIDTH    = `INSTRUCTION_WIDTH,
    localparam int IDX_W         = $clog2(WARPS_PER_CORE)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [WARPS_PER_CORE-1:0]                 warp_fetch_req,
    input  logic [WARPS_PER_CORE-1:0][ADDR_WIDTH-1:0] warp_pc,
    output logic [WARPS_PER_CORE-1:0]                 fetch_done,
    output logic [INSTR_WIDTH-1:0]                    fetched_instruction,
    output logic [IDX_W-1:0]                          fetched_warp,
    output logic                                      busy,
    warp_fetcher_if.master                            mem
);

    typedef enum logic [1:0] {IDLE, REQUEST, DELIVER} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WARPS_PER_CORE - 1);

    state_t                  state_reg, state_next;
    logic                    valid_reg, valid_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [INSTR_WIDTH-1:0]  instr_reg, instr_next;
    logic [IDX_W-1:0]        warp_reg, warp_next;
    logic [IDX_W-1:0]        last_reg, last_next;
    logic                    mask_reg, mask_next;

    logic [WARPS_PER_CORE-1:0] eligible;
    logic                      grant_found;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          cand;

    // mask_reg is high only in the IDLE cycle right after DELIVER; it hides the
    // just-served warp while that warp is still dropping its request.
    for (genvar gi = 0; gi < WARPS_PER_CORE; gi++) begin : g_warp
        assign eligible[gi]   = warp_fetch_req[gi] & ~(mask_reg & (last_reg == IDX_W'(gi)));
        assign fetch_done[gi] = (state_reg == DELIVER) && (warp_reg == IDX_W'(gi));
    end

    // Round-robin search starting one past the last granted warp.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_reg;
        cand        = last_reg;
        for (int k = 0; k < WARPS_PER_CORE; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
        warp_next  = warp_reg;
        last_next  = last_reg;
        mask_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    valid_next = 1'b1;
                    addr_next  = warp_pc[grant_idx];
                    warp_next  = grant_idx;
                    last_next  = grant_idx;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                // Address is frozen here; warp_pc and request changes no longer matter.
                if (mem.mem_read_ready) begin
                    instr_next = mem.mem_read_data;
                    valid_next = 1'b0;
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                mask_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            instr_reg <= '0;
            warp_reg  <= '0;
            last_reg  <= LAST_IDX;
            mask_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
            instr_reg <= instr_next;
            warp_reg  <= warp_next;
            last_reg  <= last_next;
            mask_reg  <= mask_next;
        end
    end

    assign mem.mem_read_valid   = valid_reg;
    assign mem.mem_read_address = addr_reg;
    assign fetched_instruction  = instr_reg;
    assign fetched_warp         = warp_reg;
    assign busy                 = (state_reg != IDLE);

endmodule
